// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2N-bit working register, with single-cycle handling of division specials.
module mdu_iterative #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int unsigned N  = DATA_WIDTH;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LastCount = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e          state_q;
   logic [2:0]      op_q;
   logic            neg_a_q;
   logic            neg_b_q;
   logic [N-1:0]    opnd_q;
   logic [2*N-1:0]  work_q;
   logic [CW-1:0]   count_q;
   logic            done_q;
   logic [N-1:0]    result_q;

   // Accept-time decode
   logic            signed_a, signed_b, in_neg_a, in_neg_b, is_div, div_zero, div_ovf;
   logic [N-1:0]    in_mag_a, in_mag_b, fast_result;

   always_comb begin
      signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      in_neg_a = signed_a & op_a[N-1];
      in_neg_b = signed_b & op_b[N-1];
      in_mag_a = in_neg_a ? -op_a : op_a;
      in_mag_b = in_neg_b ? -op_b : op_b;
      is_div   = funct3[2];
      div_zero = (op_b == '0);
      div_ovf  = !funct3[0] && (op_a == {1'b1, {(N-1){1'b0}}}) && (op_b == '1);
      if (div_zero) begin
         fast_result = funct3[1] ? op_a : '1;
      end else begin
         fast_result = funct3[1] ? '0 : op_a;
      end
   end

   // One iteration of each algorithm; opnd_q is the multiplicand or the divisor
   logic [N:0]      mul_sum, rem_shift, diff;
   logic [2*N-1:0]  mul_next, div_next;

   always_comb begin
      mul_sum   = {1'b0, work_q[2*N-1:N]} + {1'b0, opnd_q};
      mul_next  = work_q[0] ? {mul_sum, work_q[N-1:1]} : {1'b0, work_q[2*N-1:1]};
      rem_shift = work_q[2*N-1:N-1];
      diff      = rem_shift - {1'b0, opnd_q};
      div_next  = diff[N] ? {rem_shift[N-1:0], work_q[N-2:0], 1'b0}
                          : {diff[N-1:0], work_q[N-2:0], 1'b1};
   end

   // Sign correction and result select
   logic [2*N-1:0]  prod;
   logic [N-1:0]    quot, rem, fix_result;

   always_comb begin
      prod = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
      quot = (neg_a_q ^ neg_b_q) ? -work_q[N-1:0] : work_q[N-1:0];
      rem  = neg_a_q ? -work_q[2*N-1:N] : work_q[2*N-1:N];
      case (op_q)
         3'b000:                  fix_result = prod[N-1:0];
         3'b001, 3'b010, 3'b011:  fix_result = prod[2*N-1:N];
         3'b100, 3'b101:          fix_result = quot;
         default:                 fix_result = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         opnd_q   <= '0;
         work_q   <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  if (is_div && (div_zero || div_ovf)) begin
                     result_q <= fast_result;
                     done_q   <= 1'b1;
                  end else begin
                     op_q    <= funct3;
                     neg_a_q <= in_neg_a;
                     neg_b_q <= in_neg_b;
                     opnd_q  <= is_div ? in_mag_b : in_mag_a;
                     work_q  <= {{N{1'b0}}, (is_div ? in_mag_a : in_mag_b)};
                     count_q <= '0;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               work_q  <= op_q[2] ? div_next : mul_next;
               count_q <= count_q + CW'(1);
               if (count_q == LastCount) state_q <= StFix;
            end
            StFix: begin
               result_q <= fix_result;
               done_q   <= 1'b1;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign result = result_q;

endmodule
